// File: rtl/sha_pkg.sv
// sha_pkg: shared definitions for the SHA-256 datapath helpers.
//   - add_seq_state_t : FSM state encoding of the addition sequencer.
//   - AddSeqWidth     : default word width of the sequencer (32).
//   - AddSeqNumOps    : default maximum operand count per job (5).
package sha_pkg;

  localparam int unsigned AddSeqWidth  = 32;
  localparam int unsigned AddSeqNumOps = 5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } add_seq_state_t;

endpackage

// File: rtl/CLA_nbit.sv
// CLA_nbit: WIDTH-bit adder built from generate/propagate terms.
// Ports:
//   a_i, b_i : addends
//   c_i      : carry-in
//   sum_o    : a_i + b_i + c_i mod 2^WIDTH
//   c_o      : carry-out of the top bit
module CLA_nbit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             c_i,
  output logic [WIDTH-1:0] sum_o,
  output logic             c_o
);

  logic [WIDTH-1:0] gen;
  logic [WIDTH-1:0] prop;

  assign gen  = a_i & b_i;
  assign prop = a_i ^ b_i;

  always_comb begin
    logic carry;
    carry = c_i;
    sum_o = '0;
    for (int i = 0; i < WIDTH; i++) begin
      sum_o[i] = prop[i] ^ carry;
      carry    = gen[i] | (prop[i] & carry);
    end
    c_o = carry;
  end

endmodule

// File: rtl/add_seq_ctrl.sv
// add_seq_ctrl: reduces up to NUM_OPS words to one sum mod 2^WIDTH by time-sharing a
// single CLA_nbit adder, one addition per cycle.
// Ports:
//   i_clk, i_rst          : clock, synchronous active-high reset
//   i_valid / o_ready     : job handshake; i_ops packed operands, i_nops operand count
//   o_valid / i_ready     : result handshake; o_result is the accumulated sum
//   o_carry_cnt           : carry-outs seen during the job (only with ADD_SEQ_CARRY_CNT_EN)
// Optional feature macro: ADD_SEQ_CARRY_CNT_EN
module add_seq_ctrl
  import sha_pkg::*;
#(
  parameter int unsigned WIDTH   = AddSeqWidth,
  parameter int unsigned NUM_OPS = AddSeqNumOps,
  parameter int unsigned CNT_W   = $clog2(NUM_OPS + 1)
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_valid,
  output logic                     o_ready,
  input  logic [NUM_OPS*WIDTH-1:0] i_ops,
  input  logic [CNT_W-1:0]         i_nops,
  output logic                     o_valid,
  input  logic                     i_ready,
  output logic [WIDTH-1:0]         o_result
`ifdef ADD_SEQ_CARRY_CNT_EN
  ,
  output logic [CNT_W-1:0]         o_carry_cnt
`endif
);

  localparam logic [CNT_W-1:0] NumOpsCnt = CNT_W'(NUM_OPS);
  localparam logic [CNT_W-1:0] CntOne    = CNT_W'(1);
  localparam logic [CNT_W-1:0] CntTwo    = CNT_W'(2);

  add_seq_state_t   state_q, state_d;
  logic [WIDTH-1:0] ops_q [NUM_OPS];
  logic [CNT_W-1:0] n_q, n_d;
  logic [CNT_W-1:0] idx_q, idx_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] n_in;
  logic [WIDTH-1:0] op_sel;
  logic [WIDTH-1:0] sum;
  logic             accept;

  assign accept = i_valid && (state_q == IDLE);
  // Counts above NUM_OPS are clamped rather than rejected.
  assign n_in   = (i_nops > NumOpsCnt) ? NumOpsCnt : i_nops;

  // Operand mux feeding the shared adder.
  always_comb begin
    op_sel = '0;
    for (int k = 0; k < NUM_OPS; k++) begin
      if (idx_q == CNT_W'(k)) op_sel = ops_q[k];
    end
  end

`ifdef ADD_SEQ_CARRY_CNT_EN
  logic             adder_co;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  CLA_nbit #(
    .WIDTH (WIDTH)
  ) u_cla (
    .a_i   (acc_q),
    .b_i   (op_sel),
    .c_i   (1'b0),
    .sum_o (sum),
    .c_o   (adder_co)
  );

  always_comb begin
    cnt_d = cnt_q;
    if (accept) begin
      cnt_d = '0;
    end else if (state_q == ACCUM && adder_co) begin
      cnt_d = cnt_q + CntOne;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign o_carry_cnt = cnt_q;
`else
  logic unused_carry;

  CLA_nbit #(
    .WIDTH (WIDTH)
  ) u_cla (
    .a_i   (acc_q),
    .b_i   (op_sel),
    .c_i   (1'b0),
    .sum_o (sum),
    .c_o   (unused_carry)
  );
`endif

  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    idx_d   = idx_q;
    acc_d   = acc_q;
    unique case (state_q)
      IDLE: begin
        if (i_valid) begin
          n_d     = n_in;
          idx_d   = CntOne;
          acc_d   = (n_in == '0) ? '0 : i_ops[WIDTH-1:0];
          state_d = (n_in >= CntTwo) ? ACCUM : DONE;
        end
      end
      ACCUM: begin
        acc_d = sum;
        idx_d = idx_q + CntOne;
        if (idx_q == n_q - CntOne) state_d = DONE;
      end
      DONE: begin
        if (i_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= IDLE;
      n_q     <= '0;
      idx_q   <= '0;
      acc_q   <= '0;
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      idx_q   <= idx_d;
      acc_q   <= acc_d;
    end
  end

  // Operand buffer only captures on accept; later i_ops changes are ignored.
  always_ff @(posedge i_clk) begin
    if (accept) begin
      for (int k = 0; k < NUM_OPS; k++) begin
        ops_q[k] <= i_ops[k*WIDTH +: WIDTH];
      end
    end
  end

  assign o_ready  = (state_q == IDLE);
  assign o_valid  = (state_q == DONE);
  assign o_result = acc_q;

endmodule

// File: tb/tb_add_seq_ctrl.sv
// tb_add_seq_ctrl: directed and randomized self-checking bench for add_seq_ctrl
// (WIDTH=32, NUM_OPS=5). Carry-count checks exist only with ADD_SEQ_CARRY_CNT_EN.
module tb_add_seq_ctrl;

  localparam int W  = 32;
  localparam int N  = 5;
  localparam int CW = 3;

  logic           clk = 1'b0;
  logic           i_rst;
  logic           i_valid;
  logic           o_ready;
  logic [N*W-1:0] i_ops;
  logic [CW-1:0]  i_nops;
  logic           o_valid;
  logic           i_ready;
  logic [W-1:0]   o_result;
  logic [CW-1:0]  o_carry_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  add_seq_ctrl #(
    .WIDTH   (W),
    .NUM_OPS (N),
    .CNT_W   (CW)
  ) dut (
    .i_clk       (clk),
    .i_rst       (i_rst),
    .i_valid     (i_valid),
    .o_ready     (o_ready),
    .i_ops       (i_ops),
    .i_nops      (i_nops),
    .o_valid     (o_valid),
    .i_ready     (i_ready),
    .o_result    (o_result)
`ifdef ADD_SEQ_CARRY_CNT_EN
    ,
    .o_carry_cnt (o_carry_cnt)
`endif
  );

`ifndef ADD_SEQ_CARRY_CNT_EN
  assign o_carry_cnt = '0;
`endif

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Offers one job from IDLE and waits (bounded) for o_valid; lat = cycles to o_valid.
  task automatic issue_job(input logic [N*W-1:0] ops, input logic [CW-1:0] nops,
                           output int lat);
    i_ops   = ops;
    i_nops  = nops;
    i_valid = 1'b1;
    step();
    i_valid = 1'b0;
    lat = 1;
    while (!o_valid && lat < 30) begin
      step();
      lat++;
    end
  endtask

  task automatic retire();
    i_ready = 1'b1;
    step();
    i_ready = 1'b0;
  endtask

  task automatic test_reset();
    i_rst = 1'b1;
    step();
    step();
    n_checks++; if (o_ready !== 1'b1) begin n_fail++; $display("FAIL rst_ready got %b want 1", o_ready); end
    n_checks++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid got %b want 0", o_valid); end
    n_checks++; if (o_result !== 32'h0) begin n_fail++; $display("FAIL rst_result got %h want 0", o_result); end
    n_checks++; if (o_carry_cnt !== 3'd0) begin n_fail++; $display("FAIL rst_carry got %0d want 0", o_carry_cnt); end
    i_rst = 1'b0;
    step();
    n_checks++; if (o_ready !== 1'b1) begin n_fail++; $display("FAIL rst_ready_after got %b want 1", o_ready); end
  endtask

  task automatic test_sum5();
    int lat;
    issue_job({32'd5, 32'd4, 32'd3, 32'd2, 32'd1}, 3'd5, lat);
    n_checks++; if (lat !== 5) begin n_fail++; $display("FAIL sum5_lat got %0d want 5", lat); end
    n_checks++; if (o_result !== 32'd15) begin n_fail++; $display("FAIL sum5_result got %h want f", o_result); end
    n_checks++; if (o_carry_cnt !== 3'd0) begin n_fail++; $display("FAIL sum5_carry got %0d want 0", o_carry_cnt); end
    n_checks++; if (o_ready !== 1'b0) begin n_fail++; $display("FAIL sum5_busy got %b want 0", o_ready); end
    retire();
    n_checks++; if (o_ready !== 1'b1) begin n_fail++; $display("FAIL sum5_ready_back got %b want 1", o_ready); end
    n_checks++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL sum5_valid_drop got %b want 0", o_valid); end
  endtask

  task automatic test_carry();
    int lat;
    issue_job({32'd0, 32'd0, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF}, 3'd3, lat);
    n_checks++; if (lat !== 3) begin n_fail++; $display("FAIL carry_lat got %0d want 3", lat); end
    n_checks++; if (o_result !== 32'h0) begin n_fail++; $display("FAIL carry_result got %h want 0", o_result); end
`ifdef ADD_SEQ_CARRY_CNT_EN
    n_checks++; if (o_carry_cnt !== 3'd2) begin n_fail++; $display("FAIL carry_cnt got %0d want 2", o_carry_cnt); end
`endif
    retire();
  endtask

  task automatic test_small();
    int lat;
    issue_job({32'd9, 32'd8, 32'd7, 32'd6, 32'h1234}, 3'd0, lat);
    n_checks++; if (lat !== 1) begin n_fail++; $display("FAIL n0_lat got %0d want 1", lat); end
    n_checks++; if (o_result !== 32'h0) begin n_fail++; $display("FAIL n0_result got %h want 0", o_result); end
    retire();
    issue_job({32'd1, 32'd1, 32'd1, 32'd1, 32'hDEAD_BEEF}, 3'd1, lat);
    n_checks++; if (lat !== 1) begin n_fail++; $display("FAIL n1_lat got %0d want 1", lat); end
    n_checks++; if (o_result !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL n1_result got %h want deadbeef", o_result); end
    retire();
    issue_job({32'd3, 32'd3, 32'd3, 32'd9, 32'd7}, 3'd2, lat);
    n_checks++; if (lat !== 2) begin n_fail++; $display("FAIL n2_lat got %0d want 2", lat); end
    n_checks++; if (o_result !== 32'd16) begin n_fail++; $display("FAIL n2_result got %h want 10", o_result); end
    retire();
    issue_job({32'd50, 32'd40, 32'd30, 32'd20, 32'd10}, 3'd7, lat);
    n_checks++; if (lat !== 5) begin n_fail++; $display("FAIL n7_lat got %0d want 5", lat); end
    n_checks++; if (o_result !== 32'd150) begin n_fail++; $display("FAIL n7_result got %h want 96", o_result); end
    retire();
  endtask

  task automatic test_stall();
    int lat;
    issue_job({32'd0, 32'd0, 32'd0, 32'h22, 32'h11}, 3'd2, lat);
    n_checks++; if (o_result !== 32'h33) begin n_fail++; $display("FAIL stall_result got %h want 33", o_result); end
    for (int c = 0; c < 10; c++) begin
      i_ops   = {$urandom, $urandom, $urandom, $urandom, $urandom};
      i_nops  = 3'($urandom_range(0, 7));
      i_valid = ~i_valid;
      step();
      n_checks++; if (o_result !== 32'h33) begin n_fail++; $display("FAIL stall_hold[%0d] got %h want 33", c, o_result); end
      n_checks++; if (o_ready !== 1'b0) begin n_fail++; $display("FAIL stall_ready[%0d] got %b want 0", c, o_ready); end
      n_checks++; if (o_valid !== 1'b1) begin n_fail++; $display("FAIL stall_valid[%0d] got %b want 1", c, o_valid); end
    end
    i_valid = 1'b0;
    retire();
    n_checks++; if (o_ready !== 1'b1) begin n_fail++; $display("FAIL stall_release_ready got %b want 1", o_ready); end
    n_checks++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL stall_release_valid got %b want 0", o_valid); end
  endtask

  task automatic test_mid_reset();
    int lat;
    i_ops   = {32'd5, 32'd4, 32'd3, 32'd2, 32'd1};
    i_nops  = 3'd5;
    i_valid = 1'b1;
    step();
    i_valid = 1'b0;
    step();
    step();
    n_checks++; if (o_ready !== 1'b0) begin n_fail++; $display("FAIL midrst_busy got %b want 0", o_ready); end
    i_rst = 1'b1;
    step();
    i_rst = 1'b0;
    n_checks++; if (o_ready !== 1'b1) begin n_fail++; $display("FAIL midrst_ready got %b want 1", o_ready); end
    n_checks++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_valid got %b want 0", o_valid); end
    n_checks++; if (o_result !== 32'h0) begin n_fail++; $display("FAIL midrst_result got %h want 0", o_result); end
    n_checks++; if (o_carry_cnt !== 3'd0) begin n_fail++; $display("FAIL midrst_carry got %0d want 0", o_carry_cnt); end
    issue_job({32'd500, 32'd400, 32'd300, 32'd200, 32'd100}, 3'd5, lat);
    n_checks++; if (lat !== 5) begin n_fail++; $display("FAIL midrst_job_lat got %0d want 5", lat); end
    n_checks++; if (o_result !== 32'd1500) begin n_fail++; $display("FAIL midrst_job_result got %h want 5dc", o_result); end
    retire();
  endtask

  task automatic test_back_to_back();
    logic [N*W-1:0] ops;
    logic [CW-1:0]  nops;
    logic [63:0]    ref_sum;
    int             n_eff;
    int             lat;
    int             stall;
    for (int j = 0; j < 1000; j++) begin
      ops   = {$urandom, $urandom, $urandom, $urandom, $urandom};
      nops  = 3'($urandom_range(0, 7));
      n_eff = (int'(nops) > N) ? N : int'(nops);
      ref_sum = 64'd0;
      for (int k = 0; k < n_eff; k++) ref_sum += {32'd0, ops[k*W +: W]};
      issue_job(ops, nops, lat);
      n_checks++; if (lat !== ((n_eff < 1) ? 1 : n_eff)) begin n_fail++; $display("FAIL b2b_lat[%0d] got %0d want %0d", j, lat, (n_eff < 1) ? 1 : n_eff); end
      n_checks++; if (o_result !== ref_sum[31:0]) begin n_fail++; $display("FAIL b2b_result[%0d] got %h want %h", j, o_result, ref_sum[31:0]); end
`ifdef ADD_SEQ_CARRY_CNT_EN
      n_checks++; if (32'(o_carry_cnt) !== ref_sum[63:32]) begin n_fail++; $display("FAIL b2b_carry[%0d] got %0d want %0d", j, o_carry_cnt, ref_sum[63:32]); end
`endif
      stall = $urandom_range(0, 3);
      for (int s = 0; s < stall; s++) step();
      n_checks++; if (o_result !== ref_sum[31:0]) begin n_fail++; $display("FAIL b2b_stall_hold[%0d] got %h want %h", j, o_result, ref_sum[31:0]); end
      retire();
    end
  endtask

  initial begin
    i_rst   = 1'b1;
    i_valid = 1'b0;
    i_ready = 1'b0;
    i_ops   = '0;
    i_nops  = '0;
    test_reset();
    test_sum5();
    test_carry();
    test_small();
    test_stall();
    test_mid_reset();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
